// File: rtl/sdram_rom_arbiter.sv
// sdram_rom_arbiter: shares one SDRAM ROM read port between N requesters.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   cl_addr/cl_req        per-requester address slices and request levels
//   cl_rdy/cl_dout        per-requester data-valid pulse, shared read data
//   mem_addr/mem_req      latched address and request to the SDRAM controller
//   mem_rdy/mem_dout      controller data-valid pulse and read data
//   gnt_id                index of the current/last granted requester
module sdram_rom_arbiter #(
    parameter int             N          = 5,
    parameter int             AW         = 25,
    parameter int             DW         = 16,
    parameter logic [N-1:0]   RT_MASK    = 5'b11100,
    parameter int             STARVE_MAX = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N*AW-1:0] cl_addr,
    input  logic [N-1:0]    cl_req,
    output logic [N-1:0]    cl_rdy,
    output logic [DW-1:0]   cl_dout,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_req,
    input  logic            mem_rdy,
    input  logic [DW-1:0]   mem_dout,
    output logic [2:0]      gnt_id
);

    localparam logic [7:0] SMAX    = 8'(STARVE_MAX);
    localparam logic [2:0] PTR_RST = 3'(N - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state, state_nx;
    logic [2:0] ptr_rt, ptr_nrt;
    logic [7:0] starve [N];
    logic [N-1:0] starved, rt_req, nrt_req;
    logic [2:0] win;
    logic       win_rt;
    logic       grant;

    // First set bit of m after ptr, searching ptr+1 .. ptr+N modulo N.
    function automatic logic [2:0] rr_pick(input logic [N-1:0] m,
                                           input logic [2:0]   ptr);
        logic [2:0] r;
        logic       found;
        int         idx;
        r     = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && m[idx]) begin
                r     = 3'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        starved = '0;
        for (int i = 0; i < N; i++)
            starved[i] = !RT_MASK[i] && cl_req[i] && (starve[i] == SMAX);
    end

    assign rt_req  = cl_req & RT_MASK;
    assign nrt_req = cl_req & ~RT_MASK;
    assign grant   = (state == IDLE) && (|cl_req);

    // Starved CPUs outrank video layers; starved and plain CPU share a pointer.
    always_comb begin
        win    = '0;
        win_rt = 1'b0;
        priority case (1'b1)
            |starved: win = rr_pick(starved, ptr_nrt);
            |rt_req: begin
                win    = rr_pick(rt_req, ptr_rt);
                win_rt = 1'b1;
            end
            default: win = rr_pick(nrt_req, ptr_nrt);
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant) state_nx = WAIT;
            WAIT:    if (mem_rdy) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            cl_rdy   <= '0;
            cl_dout  <= '0;
            gnt_id   <= '0;
            ptr_rt   <= PTR_RST;
            ptr_nrt  <= PTR_RST;
        end else begin
            cl_rdy <= '0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        mem_addr <= cl_addr[int'(win)*AW +: AW];
                        mem_req  <= 1'b1;
                        gnt_id   <= win;
                        if (win_rt) ptr_rt  <= win;
                        else        ptr_nrt <= win;
                    end
                end
                WAIT: begin
                    // The access always completes; a dropped request just
                    // gets no pulse.
                    if (mem_rdy) begin
                        cl_dout <= mem_dout;
                        mem_req <= 1'b0;
                        if (cl_req[gnt_id]) cl_rdy[gnt_id] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A requester being served does not age; it is cleared when granted.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (RST || RT_MASK[i] || !cl_req[i] || (grant && win == 3'(i)))
                starve[i] <= '0;
            else if (!(state != IDLE && gnt_id == 3'(i)) && starve[i] != SMAX)
                starve[i] <= starve[i] + 8'd1;
        end
    end

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// tb_sdram_rom_arbiter: scoreboard bench for sdram_rom_arbiter.
// Directed scenarios plus randomized traffic against a reference model.
module tb_sdram_rom_arbiter;

    localparam int N = 5, AW = 25, DW = 16, SMAX = 8;
    localparam bit [N-1:0] RT = 5'b11100;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N*AW-1:0] cl_addr = '0;
    logic [N-1:0]    cl_req = '0;
    logic [N-1:0]    cl_rdy;
    logic [DW-1:0]   cl_dout;
    logic [AW-1:0]   mem_addr;
    logic            mem_req;
    logic            mem_rdy = 1'b0;
    logic [DW-1:0]   mem_dout = '0;
    logic [2:0]      gnt_id;

    always #5 CLK = ~CLK;

    sdram_rom_arbiter #(.N(N), .AW(AW), .DW(DW), .RT_MASK(RT),
                        .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RST(RST), .cl_addr(cl_addr), .cl_req(cl_req),
        .cl_rdy(cl_rdy), .cl_dout(cl_dout), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_rdy(mem_rdy), .mem_dout(mem_dout),
        .gnt_id(gnt_id)
    );

    typedef struct { int id; logic [AW-1:0] addr; } gexp_t;
    typedef struct { int id; logic [DW-1:0] d; } rexp_t;

    gexp_t         gq[$];
    rexp_t         rq[$];
    logic [DW-1:0] dq[$];
    int            glog[$];

    int n_tests = 0, n_fail = 0;

    // reference model: idle/busy/responding phase, class pointers, wait ages
    int m_st = 0, m_cur = 0, m_prt = N-1, m_pnr = N-1;
    int m_cnt[N];

    // stimulus knobs
    bit pend[N];
    int rate[N];
    bit abort_en = 0, scramble = 0, auto_mem = 0, spur = 0, rst_rand = 0;
    int fixed_lat = -1;
    bit rsp_busy = 0;
    int lat = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/empty expected event", name);
    endtask

    function automatic int rr(input bit [N-1:0] m, input int ptr);
        for (int k = 1; k <= N; k++)
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic predict();
        bit [N-1:0] req, sv, rv, nv;
        int g;
        bit gr;
        req = cl_req;
        if (RST) begin
            if (m_st == 1) dq.push_back('0);
            m_st = 0; m_cur = 0; m_prt = N-1; m_pnr = N-1;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            return;
        end
        gr = 0; g = -1;
        sv = '0; rv = '0; nv = '0;
        for (int i = 0; i < N; i++) begin
            sv[i] = !RT[i] && req[i] && m_cnt[i] == SMAX;
            rv[i] = RT[i] && req[i];
            nv[i] = !RT[i] && req[i];
        end
        if (m_st == 0 && req != 0) begin
            if (sv != 0)      begin g = rr(sv, m_pnr); m_pnr = g; end
            else if (rv != 0) begin g = rr(rv, m_prt); m_prt = g; end
            else              begin g = rr(nv, m_pnr); m_pnr = g; end
            gq.push_back('{g, cl_addr[g*AW +: AW]});
            gr = 1;
        end
        if (m_st == 1 && mem_rdy) begin
            dq.push_back(mem_dout);
            if (req[m_cur]) rq.push_back('{m_cur, mem_dout});
        end
        for (int i = 0; i < N; i++) begin
            if (RT[i] || !req[i] || (gr && g == i)) m_cnt[i] = 0;
            else if (!(m_st != 0 && m_cur == i) && m_cnt[i] < SMAX)
                m_cnt[i]++;
        end
        if (m_st == 0 && gr) begin m_st = 1; m_cur = g; end
        else if (m_st == 1 && mem_rdy) m_st = 2;
        else if (m_st == 2) m_st = 0;
    endtask

    task automatic raise(input int i, input logic [AW-1:0] a);
        cl_req[i] = 1'b1;
        cl_addr[i*AW +: AW] = a;
        pend[i] = 1'b1;
    endtask

    task automatic tick();
        if (rst_rand) RST = ($urandom_range(0, 599) == 0);
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                if (cl_rdy[i] === 1'b1) begin
                    cl_req[i] = 1'b0; pend[i] = 1'b0;
                end else if (abort_en && mem_req === 1'b1 && gnt_id == 3'(i)
                             && $urandom_range(0, 29) == 0) begin
                    cl_req[i] = 1'b0; pend[i] = 1'b0;
                end else if (scramble && mem_req === 1'b1 && gnt_id == 3'(i)
                             && $urandom_range(0, 3) == 0)
                    cl_addr[i*AW +: AW] = AW'($urandom);
            end else if (rate[i] > 0 && $urandom_range(0, 99) < rate[i])
                raise(i, AW'($urandom));
            else if (scramble)
                cl_addr[i*AW +: AW] = AW'($urandom);
        end
        if (auto_mem) begin
            mem_rdy = 1'b0;
            if (mem_req === 1'b1) begin
                if (!rsp_busy) begin
                    rsp_busy = 1;
                    lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                end
                if (lat == 0) begin
                    mem_rdy = 1'b1; mem_dout = DW'($urandom); rsp_busy = 0;
                end else lat--;
            end else begin
                rsp_busy = 0;
                if (spur && $urandom_range(0, 9) == 0) begin
                    mem_rdy = 1'b1; mem_dout = DW'($urandom);
                end
            end
        end
        predict();
        @(negedge CLK);
    endtask

    function automatic bit pend_any();
        for (int i = 0; i < N; i++) if (pend[i]) return 1;
        return 0;
    endfunction

    task automatic do_reset();
        rst_rand = 0; abort_en = 0; scramble = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; rate[i] = 0; end
        cl_req = '0; mem_rdy = 1'b0; RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        glog.delete();
    endtask

    task automatic drain(input string name);
        int c;
        rst_rand = 0; RST = 1'b0; abort_en = 0; scramble = 0; auto_mem = 1;
        for (int i = 0; i < N; i++) rate[i] = 0;
        c = 0;
        while ((pend_any() || m_st != 0) && c < 300) begin tick(); c++; end
        if (pend_any() || m_st != 0) fail_now(name);
        tick(); tick();
    endtask

    task automatic wait_glog(input int n, input int maxc, input string name);
        int c;
        c = 0;
        while (glog.size() < n && c < maxc) begin tick(); c++; end
        if (glog.size() < n) fail_now(name);
    endtask

    task automatic wait_req(input string name);
        int c;
        c = 0;
        while (mem_req !== 1'b1 && c < 20) begin tick(); c++; end
        if (mem_req !== 1'b1) fail_now(name);
    endtask

    // monitor: pops expectations whenever the DUT presents an event
    logic          prev_req = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    always @(negedge CLK) begin : mon
        gexp_t ge;
        rexp_t re;
        if (mem_req === 1'b1 && prev_req !== 1'b1) begin
            if (gq.size() == 0) fail_now("grant_unexpected");
            else begin
                ge = gq.pop_front();
                check("grant_id", 32'(gnt_id), 32'(ge.id));
                check("grant_addr", 32'(mem_addr), 32'(ge.addr));
                hold_addr = ge.addr;
            end
            glog.push_back(int'(gnt_id));
        end else if (mem_req === 1'b1)
            check("addr_hold", 32'(mem_addr), 32'(hold_addr));
        if (mem_req !== 1'b1 && prev_req === 1'b1) begin
            if (dq.size() == 0) fail_now("dout_unexpected");
            else check("dout_update", 32'(cl_dout), 32'(dq.pop_front()));
        end
        if ((|cl_rdy) === 1'b1) begin
            if (rq.size() == 0) fail_now("rdy_unexpected");
            else begin
                re = rq.pop_front();
                check("rdy_vec", 32'(cl_rdy), 32'(1) << re.id);
                check("rdy_dout", 32'(cl_dout), 32'(re.d));
            end
        end
        prev_req = mem_req;
    end

    initial begin
        for (int i = 0; i < N; i++) begin pend[i] = 0; rate[i] = 0; m_cnt[i] = 0; end
        @(negedge CLK);
        do_reset();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_cl_rdy", 32'(cl_rdy), 0);
        check("rst_cl_dout", 32'(cl_dout), 0);
        check("rst_gnt_id", 32'(gnt_id), 0);

        // single request with exact cycle timing
        auto_mem = 0;
        raise(0, 25'h0001234);
        tick();
        check("single_mem_req", 32'(mem_req), 1);
        check("single_mem_addr", 32'(mem_addr), 32'h1234);
        repeat (4) tick();
        mem_rdy = 1'b1; mem_dout = 16'hBEEF;
        tick();
        mem_rdy = 1'b0;
        check("single_rdy", 32'(cl_rdy), 32'b00001);
        check("single_dout", 32'(cl_dout), 32'hBEEF);
        tick();
        check("single_rdy_off", 32'(cl_rdy), 0);
        check("single_idle", 32'(mem_req), 0);

        // class priority: bg1 before mcpu
        auto_mem = 1; spur = 0; fixed_lat = 2;
        glog.delete();
        raise(0, 25'h0000100);
        raise(3, 25'h1300000);
        wait_glog(2, 40, "prio_timeout");
        drain("prio_drain");
        check("prio_first", 32'(glog.size() > 0 ? glog[0] : -1), 3);
        check("prio_second", 32'(glog.size() > 1 ? glog[1] : -1), 0);

        // RT round-robin from reset pointer
        do_reset();
        auto_mem = 1; fixed_lat = 1;
        rate[2] = 100; rate[3] = 100; rate[4] = 100;
        wait_glog(6, 200, "rr_timeout");
        drain("rr_drain");
        for (int k = 0; k < 6; k++)
            check("rt_rr_order", 32'(glog.size() > k ? glog[k] : -1), 32'(2 + k % 3));

        // starvation promotion of scpu
        do_reset();
        auto_mem = 1; fixed_lat = 3;
        rate[2] = 100; rate[3] = 100; rate[4] = 100;
        raise(1, 25'h0ABCDE);
        wait_glog(3, 200, "starve_timeout");
        check("starve_g0", 32'(glog.size() > 0 ? glog[0] : -1), 2);
        check("starve_g1", 32'(glog.size() > 1 ? glog[1] : -1), 3);
        check("starve_g2", 32'(glog.size() > 2 ? glog[2] : -1), 1);
        drain("starve_drain");

        // abort: mcpu drops during WAIT, scpu served next
        do_reset();
        auto_mem = 1; fixed_lat = 3;
        raise(0, 25'h0000A0A);
        raise(1, 25'h0000B0B);
        wait_req("abort_req_timeout");
        check("abort_gnt", 32'(gnt_id), 0);
        cl_req[0] = 1'b0; pend[0] = 1'b0;
        wait_glog(2, 50, "abort_timeout");
        drain("abort_drain");
        check("abort_next", 32'(glog.size() > 1 ? glog[1] : -1), 1);

        // reset in WAIT
        auto_mem = 0;
        raise(4, 25'h1F0F0F0);
        wait_req("rstmid_req_timeout");
        RST = 1'b1; cl_req[4] = 1'b0; pend[4] = 1'b0;
        tick();
        RST = 1'b0;
        check("rstmid_mem_req", 32'(mem_req), 0);
        check("rstmid_cl_rdy", 32'(cl_rdy), 0);
        check("rstmid_gnt", 32'(gnt_id), 0);
        mem_rdy = 1'b1; mem_dout = 16'h1111;
        tick();
        mem_rdy = 1'b0;
        check("rstmid_late_rdy", 32'(cl_rdy), 0);
        check("rstmid_dout", 32'(cl_dout), 0);

        // randomized traffic
        do_reset();
        auto_mem = 1; spur = 1; fixed_lat = -1;
        rate[0] = 20; rate[1] = 25; rate[2] = 35; rate[3] = 30; rate[4] = 35;
        abort_en = 1; scramble = 1; rst_rand = 1;
        repeat (4000) tick();
        drain("random_drain");
        check("gq_empty", 32'(gq.size()), 0);
        check("rq_empty", 32'(rq.size()), 0);
        check("dq_empty", 32'(dq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
